// File: rtl/uart_pkg.sv
// Shared types and helpers for the single-clock UART blocks of the MxV serial link.
// Holds the receiver state encoding, the oversample ratio and divider/parity helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE = 16;

    function automatic int calc_div(input int clk_freq, input int baud, input int oversample = OVERSAMPLE);
        return clk_freq / (baud * oversample);
    endfunction

    // Returns the bit that makes the total count of ones even (XOR of all bits).
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clk pulse every CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks.
// restart zeroes the divider so the bit phase can be locked to a line edge.
module uart_baud_tick #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    import uart_pkg::*;

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// 8E1 UART receiver running on the system clock with 16x oversampling and 2-of-3 voting.
// Completed frames update the data register and the interrupt/parity/framing/overrun flags.
module uart_rx_core #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int UARTSIZE   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RX,
    input  logic                clearInterrupt,
    output logic [UARTSIZE-1:0] ReceivedData,
    output logic                RXInterruptFlag,
    output logic                PARITYERRORFlag,
    output logic                FRAMEERRORFlag,
    output logic                OVERRUNFlag
);
    import uart_pkg::*;

    localparam int OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_S0  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] OS_S1  = OSW'(OVERSAMPLE / 2);
    localparam logic [OSW-1:0] OS_DEC = OSW'(OVERSAMPLE / 2 + 1);
    localparam logic [OSW-1:0] OS_END = OSW'(OVERSAMPLE - 1);
    localparam int BCW = (UARTSIZE > 1) ? $clog2(UARTSIZE) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(UARTSIZE - 1);

    rx_state_t             state, state_next;
    logic                  rx_meta, rx_s;
    logic                  tick, restart, decide, maj, done;
    logic [OSW-1:0]        os_cnt;
    logic [BCW-1:0]        bit_cnt;
    logic [UARTSIZE-1:0]   shift_reg;
    logic                  s0, s1, perr;

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Synchronizer resets to the idle-high line level so reset release is not seen as a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    assign decide = tick && (os_cnt == OS_DEC);
    assign maj    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        restart    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    restart    = 1'b1;
                    state_next = START;
                end
            end
            START:  if (decide) state_next = maj ? IDLE : DATA;
            DATA:   if (decide && bit_cnt == BIT_LAST) state_next = PARITY;
            PARITY: if (decide) state_next = STOP;
            STOP: begin
                if (decide) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit decisions land mid-bit; the state advances there while os_cnt keeps running to the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            perr      <= 1'b0;
        end else begin
            if (restart) begin
                os_cnt  <= '0;
                bit_cnt <= '0;
            end else if (tick && state != IDLE) begin
                os_cnt <= (os_cnt == OS_END) ? '0 : os_cnt + OSW'(1);
                if (os_cnt == OS_S0) s0 <= rx_s;
                if (os_cnt == OS_S1) s1 <= rx_s;
            end
            if (decide && state == DATA) begin
                shift_reg <= {maj, shift_reg[UARTSIZE-1:1]};
                bit_cnt   <= bit_cnt + BCW'(1);
            end
            if (decide && state == PARITY) begin
                perr <= even_parity(32'(shift_reg)) ^ maj;
            end
        end
    end

    // A completing frame takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ReceivedData    <= '0;
            RXInterruptFlag <= 1'b0;
            PARITYERRORFlag <= 1'b0;
            FRAMEERRORFlag  <= 1'b0;
            OVERRUNFlag     <= 1'b0;
        end else if (done) begin
            ReceivedData    <= shift_reg;
            RXInterruptFlag <= 1'b1;
            PARITYERRORFlag <= perr;
            FRAMEERRORFlag  <= !maj;
            OVERRUNFlag     <= clearInterrupt ? 1'b0 : (OVERRUNFlag | RXInterruptFlag);
        end else if (clearInterrupt) begin
            RXInterruptFlag <= 1'b0;
            PARITYERRORFlag <= 1'b0;
            FRAMEERRORFlag  <= 1'b0;
            OVERRUNFlag     <= 1'b0;
        end
    end

endmodule
